// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution stage: widths, opcodes, FSM
// state encoding, shift kinds and small datapath helper functions.
package alu_pkg;

    localparam int WORD_W  = 32;
    localparam int SHAMT_W = 5;

    // Opcode map; values 11..15 are illegal.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_kind_t;

    // True when a result word is all zeros.
    function automatic logic is_zero(input logic [WORD_W-1:0] v);
        return (v == {WORD_W{1'b0}});
    endfunction

    // Signed overflow of X+Y (is_sub=0) or X-Y (is_sub=1) given the result.
    function automatic logic arith_ovf(input logic a_msb, input logic b_msb,
                                       input logic r_msb, input logic is_sub);
        logic signs_match;
        signs_match = (a_msb == b_msb);
        return (is_sub ? ~signs_match : signs_match) & (r_msb != a_msb);
    endfunction

    // One-bit step of the iterative shifter.
    function automatic logic [WORD_W-1:0] shift_step(input logic [WORD_W-1:0] v,
                                                     input shift_kind_t kind);
        logic [WORD_W-1:0] r;
        case (kind)
            SH_LL:   r = {v[WORD_W-2:0], 1'b0};
            SH_RL:   r = {1'b0, v[WORD_W-1:1]};
            SH_RA:   r = {v[WORD_W-1], v[WORD_W-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/set_less_than_32bit.sv
// Signed (two's complement) less-than comparator for 32-bit words.
module set_less_than_32bit
    import alu_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              lt
);

    logic signs_differ_s;

    assign signs_differ_s = a[WORD_W-1] ^ b[WORD_W-1];

    // Differing signs: the negative operand is smaller; otherwise compare magnitudes.
    always_comb begin
        if (signs_differ_s) begin
            lt = a[WORD_W-1];
        end else begin
            lt = (a[WORD_W-2:0] < b[WORD_W-2:0]);
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered, valid/ready ALU execution stage. Single-cycle ops complete on
// the accept edge; shifts iterate one bit per cycle. The result register is
// held until the downstream stage takes it.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] X,
    input  logic [WORD_W-1:0] Y,
    input  logic [OPW-1:0]    OP,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] Z,
    output logic              zero,
    output logic              ovf,
    output logic              err
);

    state_t              state_r;
    state_t              state_next_s;

    logic [WORD_W-1:0]   z_r;
    logic                zero_r;
    logic                ovf_r;
    logic                err_r;
    logic                out_valid_r;
    logic [WORD_W-1:0]   work_r;
    logic [SHAMT_W-1:0]  cnt_r;
    shift_kind_t         kind_r;

    logic [WORD_W-1:0]   sum_s;
    logic [WORD_W-1:0]   diff_s;
    logic                slt_s;
    logic [WORD_W-1:0]   res_s;
    logic                res_ovf_s;
    logic                res_err_s;
    logic                is_shift_s;
    shift_kind_t         kind_s;
    logic [SHAMT_W-1:0]  shamt_s;
    logic [WORD_W-1:0]   work_next_s;

    logic                in_ready_s;
    logic                accept_s;
    logic                load_result_s;
    logic                load_shift_s;
    logic                shift_active_s;
    logic                shift_last_s;

    assign shamt_s     = Y[SHAMT_W-1:0];
    assign sum_s       = X + Y;
    assign diff_s      = X - Y;
    assign work_next_s = shift_step(work_r, kind_r);

    set_less_than_32bit u_slt (
        .a  (X),
        .b  (Y),
        .lt (slt_s)
    );

    // Next result, flags and shift setup computed from the presented operands.
    always_comb begin
        res_s      = {WORD_W{1'b0}};
        res_ovf_s  = 1'b0;
        res_err_s  = 1'b0;
        is_shift_s = 1'b0;
        kind_s     = SH_LL;
        case (OP)
            OPW'(OP_ADD): begin
                res_s     = sum_s;
                res_ovf_s = arith_ovf(X[WORD_W-1], Y[WORD_W-1], sum_s[WORD_W-1], 1'b0);
            end
            OPW'(OP_SUB): begin
                res_s     = diff_s;
                res_ovf_s = arith_ovf(X[WORD_W-1], Y[WORD_W-1], diff_s[WORD_W-1], 1'b1);
            end
            OPW'(OP_AND):  res_s = X & Y;
            OPW'(OP_OR):   res_s = X | Y;
            OPW'(OP_XOR):  res_s = X ^ Y;
            OPW'(OP_NOR):  res_s = ~(X | Y);
            OPW'(OP_SLT):  res_s = {{(WORD_W-1){1'b0}}, slt_s};
            OPW'(OP_SLTU): res_s = {{(WORD_W-1){1'b0}}, (X < Y)};
            OPW'(OP_SLL): begin
                res_s      = X;
                is_shift_s = 1'b1;
                kind_s     = SH_LL;
            end
            OPW'(OP_SRL): begin
                res_s      = X;
                is_shift_s = 1'b1;
                kind_s     = SH_RL;
            end
            OPW'(OP_SRA): begin
                res_s      = X;
                is_shift_s = 1'b1;
                kind_s     = SH_RA;
            end
            default: begin
                res_s     = {WORD_W{1'b0}};
                res_err_s = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; DONE may hand off directly to a new op.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = load_shift_s ? ST_SHIFT : ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == SHAMT_W'(1)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_next_s = load_shift_s ? ST_SHIFT : ST_DONE;
                end else if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake readiness and datapath load strobes.
    always_comb begin
        in_ready_s     = 1'b0;
        shift_active_s = 1'b0;
        case (state_r)
            ST_IDLE:  in_ready_s = 1'b1;
            ST_SHIFT: shift_active_s = 1'b1;
            ST_DONE:  in_ready_s = out_ready;
            default:  in_ready_s = 1'b0;
        endcase
        accept_s      = in_valid & in_ready_s;
        load_shift_s  = accept_s & is_shift_s & (shamt_s != {SHAMT_W{1'b0}});
        load_result_s = accept_s & ~load_shift_s;
        shift_last_s  = shift_active_s & (cnt_r == SHAMT_W'(1));
    end

    // Result, flag, working-register and counter updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_r         <= {WORD_W{1'b0}};
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            work_r      <= {WORD_W{1'b0}};
            cnt_r       <= {SHAMT_W{1'b0}};
            kind_r      <= SH_LL;
        end else begin
            out_valid_r <= (state_next_s == ST_DONE);
            if (load_result_s) begin
                z_r    <= res_s;
                zero_r <= is_zero(res_s);
                ovf_r  <= res_ovf_s;
                err_r  <= res_err_s;
            end else if (shift_last_s) begin
                z_r    <= work_next_s;
                zero_r <= is_zero(work_next_s);
                ovf_r  <= 1'b0;
                err_r  <= 1'b0;
            end
            if (load_shift_s) begin
                work_r <= X;
                cnt_r  <= shamt_s;
                kind_r <= kind_s;
            end else if (shift_active_s) begin
                work_r <= work_next_s;
                cnt_r  <= cnt_r - SHAMT_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign Z         = z_r;
    assign zero      = zero_r;
    assign ovf       = ovf_r;
    assign err       = err_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: table-driven vectors through a
// scoreboard queue, plus hand-written backpressure and reset sequences.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] X = 32'd0;
    logic [31:0] Y = 32'd0;
    logic [3:0]  OP = 4'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] Z;
    logic        zero;
    logic        ovf;
    logic        err;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        zf;
        logic        of;
        logic        ef;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] z;
        logic        zf;
        logic        of;
        logic        ef;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   head_seen = 1'b0;
    vec_t vecs[15];

    alu_exec_stage #(.OPW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .OP        (OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: check latency when a result first appears, contents when it is taken.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: out_valid=1 with Z=%h, expected no result (cycle %0d)", Z, cyc);
            end else begin
                if (!head_seen) begin
                    head_seen = 1'b1;
                    if (q[0].lat != 0) chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                end
                if (out_ready) begin
                    chk("Z", Z, q[0].z);
                    chk("zero", {31'd0, zero}, {31'd0, q[0].zf});
                    chk("ovf", {31'd0, ovf}, {31'd0, q[0].of});
                    chk("err", {31'd0, err}, {31'd0, q[0].ef});
                    void'(q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    // Present one op until accepted; push its expectation at the accepting cycle.
    task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input exp_t e);
        bit done = 1'b0;
        in_valid = 1'b1;
        OP = op;
        X = x;
        Y = y;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc;
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op %0d not accepted, expected accept within 100 cycles", op);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{OP_SLT,  32'hFFFFFFFF, 32'h70FFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{OP_SLT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{OP_SLTU, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1};
        vecs[4]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
        vecs[5]  = '{OP_SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32};
        vecs[6]  = '{OP_SRL,  32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0, 1'b0, 32};
        vecs[7]  = '{OP_SLL,  32'h00000003, 32'd0,        32'h00000003, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{4'd12,   32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1'b0, 1'b1, 1};
        vecs[9]  = '{OP_XOR,  32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1};
        vecs[12] = '{OP_SLL,  32'h00000001, 32'd4,        32'h00000010, 1'b0, 1'b0, 1'b0, 5};
        vecs[13] = '{OP_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1};
        vecs[14] = '{OP_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 1'b0, 1};

        // Reset state.
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_Z", Z, 32'd0);
        chk("rst_flags", {29'd0, zero, ovf, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors, back-to-back with out_ready held high.
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].op, vecs[i].x, vecs[i].y,
                 '{z: vecs[i].z, zf: vecs[i].zf, of: vecs[i].of, ef: vecs[i].ef,
                   lat: vecs[i].lat, acc: 0});
        end
        drain();

        // Backpressure: ADD result held while out_ready is low; new input ignored.
        out_ready = 1'b0;
        send(OP_ADD, 32'd1, 32'd2, '{z: 32'd3, zf: 1'b0, of: 1'b0, ef: 1'b0, lat: 1, acc: 0});
        in_valid = 1'b1;
        OP = OP_SUB;
        X = 32'd9;
        Y = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_Z", Z, 32'd3);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(OP_AND, 32'h000000F0, 32'h0000003C,
             '{z: 32'h00000030, zf: 1'b0, of: 1'b0, ef: 1'b0, lat: 1, acc: 0});
        drain();

        // Reset in the middle of SLL by 20: operation discarded.
        send(OP_SLL, 32'd1, 32'd20, '{z: 32'h00100000, zf: 1'b0, of: 1'b0, ef: 1'b0, lat: 21, acc: 0});
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        head_seen = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_Z", Z, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_no_result", {31'd0, out_valid}, 32'd0);

        // Normal operation resumes after reset.
        send(OP_ADD, 32'd2, 32'd3, '{z: 32'd5, zf: 1'b0, of: 1'b0, ef: 1'b0, lat: 1, acc: 0});
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
